cakegame_control: RTL and testbench
===================================

Name: cakegame_control

Overview:
- Moore control unit for the cake memory game.
- Drives every control input of the cake game datapath (memory address counter, play register, show/timeout/points counters, output mux select).
- Consumes the datapath status flags.
- Runs a round per memory item: show item, wait for player press, compare, score or lose a life, advance. Ends on win or when lives are exhausted.

Parameters:
- LIVES, 3, misses allowed before game over; legal range 1..3.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  game start/restart request, level sampled per cycle
- dificuldade_in  in  1  difficulty select, latched at game start
- end_mem_counter  in  1  datapath: address counter at last item
- correct_play  in  1  datapath: registered play equals memory item
- has_play  in  1  datapath: one-cycle button-press pulse
- end_show  in  1  datapath: show timer terminal count
- half_show  in  1  datapath: show timer midpoint pulse
- timeout  in  1  datapath: play timeout terminal count
- out_sel  out  2  00 blank, 01 memory item, 10 live buttons
- dificuldade  out  1  latched difficulty to datapath ROM mux
- clear_reg, enable_reg  out  1 each  play register control
- clear_mem_counter, enable_mem_counter  out  1 each  address counter control
- clear_show_counter, enable_show_counter  out  1 each  show timer control
- enable_timeout_counter  out  1  timeout timer run; low also clears it
- clear_points_counter, enable_points_counter  out  1 each  score counter control
- done  out  1  game finished
- won  out  1  valid when done: 1 = all items processed, 0 = lives exhausted
- lives_left  out  2  remaining lives
- db_state  out  4  current state code

Behaviour:
- State register plus lives register (2b) and latched-difficulty register. All reset asynchronously on reset=0 to: state IDLE, lives 0, dificuldade 0.
- Control outputs are decoded combinationally from state only. Any output not listed for a state is 0.
- In IDLE: all outputs 0, db_state=0.
- States (db_state code):
  - IDLE(0): start=1 -> PREPARE.
  - PREPARE(1): clear_reg, clear_mem_counter, clear_points_counter = 1; lives<=LIVES; dificuldade<=dificuldade_in. Always -> LOAD.
  - LOAD(2): clear_show_counter=1, clear_reg=1. Always -> SHOW.
  - SHOW(3): out_sel=01, enable_show_counter=1. end_show -> WAIT_PLAY. has_play ignored.
  - WAIT_PLAY(4): out_sel=10, enable_timeout_counter=1. has_play -> REGISTER; else timeout -> MISS. If both in the same cycle, has_play wins.
  - REGISTER(5): out_sel=10, enable_reg=1. Always -> COMPARE.
  - COMPARE(6): out_sel=10. correct_play -> HIT, else MISS.
  - HIT(7): enable_points_counter=1. Always -> NEXT.
  - MISS(8): lives<=lives-1. If lives==1 on entry -> END_LOSE, else -> NEXT.
  - NEXT(9): end_mem_counter -> END_WIN; else enable_mem_counter=1 and -> LOAD.
  - END_WIN(10): done=1, won=1.
  - END_LOSE(11): done=1, won=0.
  - From END_WIN or END_LOSE: start=1 -> PREPARE.
- Unused codes 12-15 -> IDLE on the next clock.
- Latency:
  - start in IDLE -> PREPARE at next edge; SHOW reached 2 cycles later.
  - Every clear/enable pulse from PREPARE, LOAD, REGISTER, HIT and NEXT is exactly 1 cycle.
- start outside IDLE/END states is ignored. dificuldade holds its value across the whole game.
- lives_left = lives register. It never underflows: MISS with lives==1 goes to 0 then END_LOSE.
- Score wrap (3-bit, modulo 8) is a datapath property. This block does not read points.
- Asynchronous reset mid-game: immediate return to IDLE with all outputs 0. Datapath counters are not cleared until the next PREPARE.

Optional Feature:
- Macro CAKEGAME_BLINK_EN.
- Enabled: adds a 1-bit half flag.
  - Cleared in LOAD and by reset.
  - Set in SHOW when half_show=1.
  - In SHOW, out_sel=01 while the flag is 0 and 00 once it is set (item shown for first half only; harder recall).
- Disabled: no flag; out_sel=01 for the entire SHOW state.

Test Plan:
- reset=0 during SHOW -> db_state=0, all outputs 0, lives_left=0. Release reset, start=1 one cycle -> db_state=1 with clear_mem_counter=clear_points_counter=1 for exactly 1 cycle, lives_left=3; db_state=3, out_sel=01 two cycles after PREPARE.
- Hit path: end_show pulse -> WAIT_PLAY (out_sel=10, enable_timeout_counter=1). has_play -> enable_reg=1 one cycle. correct_play=1 -> enable_points_counter=1 one cycle. end_mem_counter=0 -> enable_mem_counter=1 one cycle, then db_state=2.
- Three rounds ending in timeout (LIVES=3) -> lives_left 2,1,0. Third miss -> END_LOSE, done=1, won=0. start with dificuldade_in=1 -> PREPARE, lives_left=3, dificuldade=1.
- has_play and timeout asserted in the same WAIT_PLAY cycle -> next state REGISTER(5), lives_left unchanged.
- NEXT with end_mem_counter=1 -> END_WIN, done=1, won=1, enable_mem_counter stays 0. start=0 holds END_WIN indefinitely.
- CAKEGAME_BLINK_EN defined: half_show pulse 500 cycles into SHOW -> out_sel=00 from next cycle until WAIT_PLAY; next round's SHOW starts with out_sel=01. Without macro: out_sel=01 throughout SHOW.

Source files
------------

// File: rtl/cakegame_control.sv
// cakegame_control: Moore control unit sequencing show/play/compare rounds of the cake memory game.
// Optional macro CAKEGAME_BLINK_EN blanks the shown item after the show-timer midpoint.
`default_nettype none

module cakegame_control #(
    parameter int LIVES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       dificuldade_in,
    input  logic       end_mem_counter,
    input  logic       correct_play,
    input  logic       has_play,
    input  logic       end_show,
    input  logic       half_show,
    input  logic       timeout,
    output logic [1:0] out_sel,
    output logic       dificuldade,
    output logic       clear_reg,
    output logic       enable_reg,
    output logic       clear_mem_counter,
    output logic       enable_mem_counter,
    output logic       clear_show_counter,
    output logic       enable_show_counter,
    output logic       enable_timeout_counter,
    output logic       clear_points_counter,
    output logic       enable_points_counter,
    output logic       done,
    output logic       won,
    output logic [1:0] lives_left,
    output logic [3:0] db_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PREPARE   = 4'd1,
        S_LOAD      = 4'd2,
        S_SHOW      = 4'd3,
        S_WAIT_PLAY = 4'd4,
        S_REGISTER  = 4'd5,
        S_COMPARE   = 4'd6,
        S_HIT       = 4'd7,
        S_MISS      = 4'd8,
        S_NEXT      = 4'd9,
        S_END_WIN   = 4'd10,
        S_END_LOSE  = 4'd11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic       dif_q, dif_d;
    logic       half_q, half_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lives_q <= 2'd0;
            dif_q   <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            dif_q   <= dif_d;
            half_q  <= half_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        dif_d   = dif_q;
        half_d  = half_q;
        case (state_q)
            // Lives and difficulty are captured on the accepting edge so they are visible in PREPARE.
            S_IDLE, S_END_WIN, S_END_LOSE: begin
                if (start) begin
                    state_d = S_PREPARE;
                    lives_d = 2'(LIVES);
                    dif_d   = dificuldade_in;
                end
            end
            S_PREPARE:  state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_SHOW;
                half_d  = 1'b0;
            end
            S_SHOW: begin
`ifdef CAKEGAME_BLINK_EN
                if (half_show) half_d = 1'b1;
`endif
                if (end_show) state_d = S_WAIT_PLAY;
            end
            S_WAIT_PLAY: begin
                if (has_play)     state_d = S_REGISTER;
                else if (timeout) state_d = S_MISS;
            end
            S_REGISTER: state_d = S_COMPARE;
            S_COMPARE:  state_d = correct_play ? S_HIT : S_MISS;
            S_HIT:      state_d = S_NEXT;
            S_MISS: begin
                lives_d = lives_q - 2'd1;
                state_d = (lives_q == 2'd1) ? S_END_LOSE : S_NEXT;
            end
            S_NEXT:     state_d = end_mem_counter ? S_END_WIN : S_LOAD;
            default:    state_d = S_IDLE;
        endcase
    end

    logic unused_half_show;
    assign unused_half_show = half_show;

    always_comb begin
        out_sel                = 2'b00;
        clear_reg              = 1'b0;
        enable_reg             = 1'b0;
        clear_mem_counter      = 1'b0;
        enable_mem_counter     = 1'b0;
        clear_show_counter     = 1'b0;
        enable_show_counter    = 1'b0;
        enable_timeout_counter = 1'b0;
        clear_points_counter   = 1'b0;
        enable_points_counter  = 1'b0;
        done                   = 1'b0;
        won                    = 1'b0;
        case (state_q)
            S_PREPARE: begin
                clear_reg            = 1'b1;
                clear_mem_counter    = 1'b1;
                clear_points_counter = 1'b1;
            end
            S_LOAD: begin
                clear_show_counter = 1'b1;
                clear_reg          = 1'b1;
            end
            S_SHOW: begin
                out_sel             = half_q ? 2'b00 : 2'b01;
                enable_show_counter = 1'b1;
            end
            S_WAIT_PLAY: begin
                out_sel                = 2'b10;
                enable_timeout_counter = 1'b1;
            end
            S_REGISTER: begin
                out_sel    = 2'b10;
                enable_reg = 1'b1;
            end
            S_COMPARE:  out_sel = 2'b10;
            S_HIT:      enable_points_counter = 1'b1;
            S_NEXT:     enable_mem_counter = ~end_mem_counter;
            S_END_WIN: begin
                done = 1'b1;
                won  = 1'b1;
            end
            S_END_LOSE: done = 1'b1;
            default: ;
        endcase
    end

    assign dificuldade = dif_q;
    assign lives_left  = lives_q;
    assign db_state    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cakegame_control.sv
// tb_cakegame_control: directed stimulus against a rule-level game model, checked every falling edge.
`default_nettype none

module tb_cakegame_control;

    localparam int LIVES = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 0, dificuldade_in = 0, end_mem_counter = 0, correct_play = 0;
    logic has_play = 0, end_show = 0, half_show = 0, timeout = 0;
    logic [1:0] out_sel, lives_left;
    logic [3:0] db_state;
    logic dificuldade, clear_reg, enable_reg, clear_mem_counter, enable_mem_counter;
    logic clear_show_counter, enable_show_counter, enable_timeout_counter;
    logic clear_points_counter, enable_points_counter, done, won;

    int checks = 0;
    int failures = 0;
    bit armed = 0;

`ifdef CAKEGAME_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    cakegame_control #(.LIVES(LIVES)) dut (
        .clock(clock), .reset(reset), .start(start), .dificuldade_in(dificuldade_in),
        .end_mem_counter(end_mem_counter), .correct_play(correct_play), .has_play(has_play),
        .end_show(end_show), .half_show(half_show), .timeout(timeout),
        .out_sel(out_sel), .dificuldade(dificuldade), .clear_reg(clear_reg),
        .enable_reg(enable_reg), .clear_mem_counter(clear_mem_counter),
        .enable_mem_counter(enable_mem_counter), .clear_show_counter(clear_show_counter),
        .enable_show_counter(enable_show_counter), .enable_timeout_counter(enable_timeout_counter),
        .clear_points_counter(clear_points_counter), .enable_points_counter(enable_points_counter),
        .done(done), .won(won), .lives_left(lives_left), .db_state(db_state)
    );

    always #5 clock = ~clock;

    // Game model: phase number, remaining lives, latched difficulty, blink flag.
    int   m_phase = 0;
    int   m_lives = 0;
    logic m_dif   = 0;
    logic m_half  = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_lives = 0; m_dif = 0; m_half = 0;
        end else if (m_phase == 0 || m_phase == 10 || m_phase == 11) begin
            if (start) begin m_phase = 1; m_lives = LIVES; m_dif = dificuldade_in; end
        end else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) begin m_phase = 3; m_half = 0; end
        else if (m_phase == 3) begin
            if (half_show && BLINK) m_half = 1;
            if (end_show) m_phase = 4;
        end else if (m_phase == 4) begin
            if (has_play) m_phase = 5; else if (timeout) m_phase = 8;
        end else if (m_phase == 5) m_phase = 6;
        else if (m_phase == 6) m_phase = correct_play ? 7 : 8;
        else if (m_phase == 7) m_phase = 9;
        else if (m_phase == 8) begin
            m_lives = m_lives - 1;
            m_phase = (m_lives == 0) ? 11 : 9;
        end else if (m_phase == 9) m_phase = end_mem_counter ? 10 : 2;
        else m_phase = 0;
    end

    // Control strobes per phase: {clr_reg,en_reg,clr_mem,en_mem,clr_show,en_show,en_to,clr_pts,en_pts,done,won}
    logic [10:0] strobe_tbl [0:11];
    initial begin
        strobe_tbl[0]  = 11'b00000000000;
        strobe_tbl[1]  = 11'b10100001000;
        strobe_tbl[2]  = 11'b10001000000;
        strobe_tbl[3]  = 11'b00000100000;
        strobe_tbl[4]  = 11'b00000010000;
        strobe_tbl[5]  = 11'b01000000000;
        strobe_tbl[6]  = 11'b00000000000;
        strobe_tbl[7]  = 11'b00000000100;
        strobe_tbl[8]  = 11'b00000000000;
        strobe_tbl[9]  = 11'b00010000000;
        strobe_tbl[10] = 11'b00000000011;
        strobe_tbl[11] = 11'b00000000010;
    end

    function automatic logic [19:0] model_vec();
        logic [10:0] s;
        logic [1:0]  sel;
        s = strobe_tbl[m_phase];
        if (m_phase == 9 && end_mem_counter) s = 11'b0;
        sel = 2'b00;
        if (m_phase == 3) sel = m_half ? 2'b00 : 2'b01;
        if (m_phase >= 4 && m_phase <= 6) sel = 2'b10;
        return {sel, m_dif, s, 2'(m_lives), 4'(m_phase)};
    endfunction

    wire [19:0] dut_vec = {out_sel, dificuldade, clear_reg, enable_reg, clear_mem_counter,
                           enable_mem_counter, clear_show_counter, enable_show_counter,
                           enable_timeout_counter, clear_points_counter, enable_points_counter,
                           done, won, lives_left, db_state};

    always @(negedge clock) begin
        if (armed) begin
            logic [19:0] e;
            e = model_vec();
            checks++;
            if (dut_vec !== e) begin
                failures++;
                $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_vec, e);
            end
        end
    end

    task automatic chk(input string name, input int actual, input int want);
        checks++;
        if (actual != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, actual, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        armed = 1;
        tick(); tick();
        reset = 1'b1;
        chk("idle_state", db_state, 0);
        chk("idle_lives", lives_left, 0);

        // Start, then reset asynchronously while in SHOW.
        start = 1; tick(); start = 0;
        chk("prep_state", db_state, 1);
        chk("prep_clr_mem", clear_mem_counter, 1);
        chk("prep_clr_pts", clear_points_counter, 1);
        chk("prep_lives", lives_left, 3);
        tick();
        chk("load_state", db_state, 2);
        chk("load_clr_mem_off", clear_mem_counter, 0);
        tick();
        chk("show_state", db_state, 3);
        chk("show_sel", out_sel, 1);
        reset = 1'b0; #1;
        chk("rst_state", db_state, 0);
        chk("rst_lives", lives_left, 0);
        chk("rst_sel", out_sel, 0);
        chk("rst_en_show", enable_show_counter, 0);
        tick(); reset = 1'b1;

        // Fresh game; half_show 500 cycles into SHOW.
        start = 1; tick(); start = 0; tick(); tick();
        repeat (499) tick();
        half_show = 1; tick(); half_show = 0;
        chk("blink_sel", out_sel, BLINK ? 0 : 1);
        repeat (3) tick();
        chk("blink_sel_hold", out_sel, BLINK ? 0 : 1);

        // Hit path with has_play and timeout colliding.
        end_show = 1; tick(); end_show = 0;
        chk("wait_state", db_state, 4);
        chk("wait_sel", out_sel, 2);
        chk("wait_en_to", enable_timeout_counter, 1);
        has_play = 1; timeout = 1; tick(); has_play = 0; timeout = 0;
        chk("collide_state", db_state, 5);
        chk("reg_en", enable_reg, 1);
        chk("collide_lives", lives_left, 3);
        correct_play = 1; tick();
        chk("cmp_state", db_state, 6);
        tick();
        chk("hit_en_pts", enable_points_counter, 1);
        correct_play = 0; tick();
        chk("next_en_mem", enable_mem_counter, 1);
        tick();
        chk("reload_state", db_state, 2);
        chk("reload_en_mem_off", enable_mem_counter, 0);
        tick();
        chk("show2_sel", out_sel, 1);

        // Three timeouts exhaust the lives.
        for (int r = 0; r < 3; r++) begin
            end_show = 1; tick(); end_show = 0;
            timeout = 1; tick(); timeout = 0;
            chk("miss_state", db_state, 8);
            tick();
            chk("miss_lives", lives_left, 2 - r);
            if (r < 2) begin
                chk("miss_next", db_state, 9);
                tick(); tick();
            end
        end
        chk("lose_state", db_state, 11);
        chk("lose_done", done, 1);
        chk("lose_won", won, 0);

        // Restart with difficulty 1; one wrong play then a winning hit.
        dificuldade_in = 1; start = 1; tick(); start = 0; dificuldade_in = 0;
        chk("restart_state", db_state, 1);
        chk("restart_lives", lives_left, 3);
        chk("restart_dif", dificuldade, 1);
        tick(); tick();
        end_show = 1; tick(); end_show = 0;
        has_play = 1; tick(); has_play = 0;
        tick(); tick();
        chk("wrong_state", db_state, 8);
        tick();
        chk("wrong_lives", lives_left, 2);
        chk("dif_held", dificuldade, 1);
        tick(); tick();
        end_show = 1; tick(); end_show = 0;
        has_play = 1; tick(); has_play = 0;
        correct_play = 1; tick(); tick();
        end_mem_counter = 1; tick();
        chk("last_next_state", db_state, 9);
        chk("last_en_mem", enable_mem_counter, 0);
        tick();
        correct_play = 0; end_mem_counter = 0;
        chk("win_state", db_state, 10);
        chk("win_done", done, 1);
        chk("win_won", won, 1);
        repeat (20) tick();
        chk("win_hold", db_state, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
